chimera_pmu_sequencer: RTL and testbench
========================================

# chimera_pmu_sequencer

Parametrised power-sequencing controller for the Chimera cluster domains. It replaces static tie-offs of the per-cluster reset, clock-gate and isolation pins with ordered power-off and power-on sequences, including an isolation-acknowledge handshake and timeout. It sits in the SoC domain between a register-mapped request port (or a testbench driver) and the `pmu_*_clusters` pins of the top wrapper. It serves one request at a time for any of `NumClusters` clusters.

## Interface
- `NumClusters`, 5: number of cluster power domains.
- `BootOn`, all ones (`NumClusters` bits): per-cluster power state after reset.
- `ClkSettleCycles`, 4: cycles between a clock-enable edge and the following reset edge.
- `RstHoldCycles`, 8: cycles between reset release and isolation release.
- `IsoTimeoutCycles`, 64: maximum cycles to wait for an isolation-ack edge.
- `IdxW`, `$clog2(NumClusters)` (minimum 1): width of the cluster index.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: high in IDLE only.
- `req_idx_i`, in, `IdxW`: target cluster.
- `req_on_i`, in, 1: 1 = power on, 0 = power off.
- `done_o`, out, 1: one-cycle completion pulse.
- `err_o`, out, 1: qualifies `done_o`; high on timeout or illegal index.
- `busy_o`, out, 1: high whenever the FSM is not in IDLE.
- `cluster_on_o`, out, `NumClusters`: committed power state of each cluster.
- `rst_clusters_no`, out, `NumClusters`: active-low cluster resets.
- `clk_en_clusters_o`, out, `NumClusters`: 1 = cluster clock running.
- `iso_en_clusters_o`, out, `NumClusters`: 1 = cluster outputs isolated.
- `iso_ack_clusters_i`, in, `NumClusters`: isolation acknowledge from each cluster.

## Operation
- Reset values:
  - `rst_clusters_no` = `clk_en_clusters_o` = `cluster_on_o` = `BootOn`.
  - `iso_en_clusters_o` = `~BootOn`.
  - `done_o` = `err_o` = `busy_o` = 0; `req_ready_o` = 1.
- A request is accepted on `req_valid_i && req_ready_o`. The index and direction are latched, and only that cluster's bits change during the sequence.
- Illegal index (`idx >= NumClusters`): go to DONE with `err_o` = 1. No pin changes.
- Target state already reached (`cluster_on_o[idx] == req_on`): go to DONE with `err_o` = 0. No pin changes.
- Power-off sequence: IDLE → ISO_ASSERT → ISO_WAIT → CLK_WAIT → DONE.
  - ISO_ASSERT sets `iso_en`.
  - ISO_WAIT waits for `ack` = 1. On ack, clear `clk_en` and load the timer with `ClkSettleCycles`.
  - When the timer reaches zero, clear `rst_n` and clear `cluster_on`.
- Power-on sequence: IDLE → CLK_WAIT → RST_WAIT → ACK_WAIT → DONE.
  - Entry sets `clk_en` and loads `ClkSettleCycles`.
  - On expiry, set `rst_n` and load `RstHoldCycles`.
  - On expiry, clear `iso_en`.
  - ACK_WAIT waits for `ack` = 0, then sets `cluster_on`.
- Timeout: ISO_WAIT and ACK_WAIT each load `IsoTimeoutCycles` on entry. If the timer expires without the ack edge, go to DONE with `err_o` = 1.
  - Power-off timeout: `iso_en` is cleared, clock and reset stay untouched, `cluster_on` stays 1.
  - Power-on timeout: `iso_en` stays 1, clock and reset stay released, `cluster_on` stays 0.
- DONE lasts exactly one cycle and returns to IDLE. `done_o` is asserted in that cycle.
- A new request is accepted no earlier than the cycle after `done_o`.
- `rst_i` asserted mid-sequence: on the next edge every output returns to its reset value. The in-flight request is dropped and no `done_o` is issued.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs except `req_ready_o`, which is a decode of the state register.
- Let T0 be the handshake cycle.
- Power-off with ack first sampled high at Ta (Ta ≥ T2):
  - `iso_en` = 1 from T1.
  - `clk_en` = 0 from Ta+1.
  - `rst_n` = 0, `done_o` = 1 and `cluster_on` = 0 at Ta+1+ClkSettleCycles.
- Power-on with ack first sampled low at Tb:
  - `clk_en` = 1 from T1.
  - `rst_n` = 1 from T1+ClkSettleCycles.
  - `iso_en` = 0 from T1+ClkSettleCycles+RstHoldCycles.
  - `done_o` = 1 at Tb+1.
- No-op and illegal-index requests: `done_o` at T1.
- Timer rules:
  - Down-counter of width `$clog2(max(all cycle params)+1)`. "Expire" means the counter equals zero.
  - A parameter value of 0 means expiry in the cycle after load.
  - The counter saturates at 0.

## Structure
- `chimera_pmu_pkg` holds:
  - the `pmu_state_e` enum (IDLE, ISO_ASSERT, ISO_WAIT, CLK_WAIT, RST_WAIT, ACK_WAIT, DONE);
  - the `pmu_req_t` struct (idx, on);
  - a `PmuTimerW` helper function.
- Sub-module `chimera_pmu_timer`: loadable down-counter with `load_i`, `value_i` and `expired_o`. One instance is shared by all states.

## Test plan
- Reset, then read outputs → `cluster_on_o` = `BootOn` = 5'b11111, `iso_en` = 0, `req_ready_o` = 1.
- Power-off cluster 2; ack = `iso_en` delayed 2 cycles; ClkSettleCycles = 4:
  - `iso_en[2]` rises at T1, `clk_en[2]` falls at T4, `rst_n[2]` falls with `done_o` at T8, `err_o` = 0;
  - all other bits unchanged.
- Power-on cluster 2 with ClkSettleCycles = 4, RstHoldCycles = 8, ack following `iso_en` by 2 cycles:
  - `clk_en` rises at T1, `rst_n` rises at T5, `iso_en` falls at T13;
  - `done_o` at T16 and `cluster_on[2]` = 1.
- Power-off cluster 0 with ack stuck at 0 and IsoTimeoutCycles = 64:
  - `done_o` = `err_o` = 1 after 64 cycles in ISO_WAIT;
  - `iso_en[0]` returns to 0 and `cluster_on[0]` stays 1.
- Request idx 7 with NumClusters = 5 → `done_o` and `err_o` at T1, no pin change.
- Request on for an already-on cluster → `done_o` at T1 with `err_o` = 0, no pin change.
- Assert `rst_i` during CLK_WAIT of a power-off → all outputs return to reset values on the next edge and no `done_o` is issued.

Source files
------------

// File: rtl/chimera_pmu_pkg.sv
// -----------------------------------------------------------------------------
// chimera_pmu_pkg
// Shared types and helpers for the Chimera cluster power-sequencing controller.
//   pmu_state_e : sequencer FSM states
//   pmu_req_t   : latched request payload (cluster index, direction)
//   PmuTimerW   : width of the shared down-counter for a set of cycle params
// -----------------------------------------------------------------------------
package chimera_pmu_pkg;

    // Upper bound on the cluster index width carried in the request payload.
    localparam int unsigned PmuIdxMaxW = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISO_ASSERT = 3'd1,
        ISO_WAIT   = 3'd2,
        CLK_WAIT   = 3'd3,
        RST_WAIT   = 3'd4,
        ACK_WAIT   = 3'd5,
        DONE       = 3'd6
    } pmu_state_e;

    typedef struct packed {
        logic [PmuIdxMaxW-1:0] idx;
        logic                  on;
    } pmu_req_t;

    // Counter width able to hold the largest of the three cycle parameters.
    function automatic int unsigned PmuTimerW(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage : chimera_pmu_pkg

// File: rtl/chimera_pmu_timer.sv
// -----------------------------------------------------------------------------
// chimera_pmu_timer
// Loadable, saturating down-counter shared by all sequencer wait states.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load value_i this cycle
//   value_i      : wait length in cycles
//   expired_o    : counter is zero
// The load cycle itself counts as the first wait cycle, so a load of N expires
// N cycles after the load edge; a load of 0 expires in the cycle after load.
// -----------------------------------------------------------------------------
module chimera_pmu_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // Load (minus the load cycle) or count down, saturating at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= (value_i == '0) ? '0 : value_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule : chimera_pmu_timer

// File: rtl/chimera_pmu_sequencer.sv
// -----------------------------------------------------------------------------
// chimera_pmu_sequencer
// Ordered power-off / power-on sequencing of per-cluster reset, clock-enable
// and isolation pins, one request at a time, with an isolation-ack handshake
// and timeout.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : request handshake (ready only in IDLE)
//   req_idx_i, req_on_i   : target cluster, 1 = power on / 0 = power off
//   done_o, err_o         : one-cycle completion pulse and its error qualifier
//   busy_o                : sequencer not idle
//   cluster_on_o          : committed power state per cluster
//   rst_clusters_no       : active-low cluster resets
//   clk_en_clusters_o     : cluster clock enables
//   iso_en_clusters_o     : cluster output isolation enables
//   iso_ack_clusters_i    : isolation acknowledge from each cluster
// -----------------------------------------------------------------------------
module chimera_pmu_sequencer
    import chimera_pmu_pkg::*;
#(
    parameter int unsigned             NumClusters      = 5,
    parameter logic [NumClusters-1:0]  BootOn           = '1,
    parameter int unsigned             ClkSettleCycles  = 4,
    parameter int unsigned             RstHoldCycles    = 8,
    parameter int unsigned             IsoTimeoutCycles = 64,
    parameter int unsigned             IdxW             = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IdxW-1:0]        req_idx_i,
    input  logic                   req_on_i,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [NumClusters-1:0] cluster_on_o,
    output logic [NumClusters-1:0] rst_clusters_no,
    output logic [NumClusters-1:0] clk_en_clusters_o,
    output logic [NumClusters-1:0] iso_en_clusters_o,
    input  logic [NumClusters-1:0] iso_ack_clusters_i
);

    localparam int unsigned TimerW = PmuTimerW(ClkSettleCycles, RstHoldCycles, IsoTimeoutCycles);

    pmu_state_e state_q, state_d;
    pmu_req_t   req_q, req_d;

    logic [NumClusters-1:0] cluster_on_d;
    logic [NumClusters-1:0] rst_n_d;
    logic [NumClusters-1:0] clk_en_d;
    logic [NumClusters-1:0] iso_en_d;
    logic                   done_d;
    logic                   err_d;
    logic                   busy_d;

    logic [NumClusters-1:0] sel_mask;
    logic [NumClusters-1:0] in_mask;
    logic                   idx_illegal;
    logic                   ack_sel;

    logic                   tmr_load;
    logic [TimerW-1:0]      tmr_value;
    logic                   tmr_expired;

    // One-hot masks for the latched request and for the incoming request.
    assign sel_mask    = NumClusters'(1) << req_q.idx;
    assign in_mask     = NumClusters'(1) << req_idx_i;
    assign idx_illegal = (32'(req_idx_i) >= NumClusters);
    assign ack_sel     = ((iso_ack_clusters_i & sel_mask) != '0);

    assign req_ready_o = (state_q == IDLE);

    chimera_pmu_timer #(
        .W (TimerW)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    // State and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            req_q             <= '0;
            cluster_on_o      <= BootOn;
            rst_clusters_no   <= BootOn;
            clk_en_clusters_o <= BootOn;
            iso_en_clusters_o <= ~BootOn;
            done_o            <= 1'b0;
            err_o             <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            cluster_on_o      <= cluster_on_d;
            rst_clusters_no   <= rst_n_d;
            clk_en_clusters_o <= clk_en_d;
            iso_en_clusters_o <= iso_en_d;
            done_o            <= done_d;
            err_o             <= err_d;
            busy_o            <= busy_d;
        end
    end

    // Next-state and next-output decode; only the selected cluster's bits move.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cluster_on_d = cluster_on_o;
        rst_n_d      = rst_clusters_no;
        clk_en_d     = clk_en_clusters_o;
        iso_en_d     = iso_en_clusters_o;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_d.idx = PmuIdxMaxW'(req_idx_i);
                    req_d.on  = req_on_i;
                    if (idx_illegal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (((cluster_on_o & in_mask) != '0) == req_on_i) begin
                        // Already in the requested state.
                        state_d = DONE;
                    end else if (req_on_i) begin
                        state_d   = CLK_WAIT;
                        clk_en_d  = clk_en_clusters_o | in_mask;
                        tmr_load  = 1'b1;
                        tmr_value = TimerW'(ClkSettleCycles);
                    end else begin
                        state_d  = ISO_ASSERT;
                        iso_en_d = iso_en_clusters_o | in_mask;
                    end
                end
            end

            ISO_ASSERT: begin
                state_d   = ISO_WAIT;
                tmr_load  = 1'b1;
                tmr_value = TimerW'(IsoTimeoutCycles);
            end

            ISO_WAIT: begin
                if (ack_sel) begin
                    state_d   = CLK_WAIT;
                    clk_en_d  = clk_en_clusters_o & ~sel_mask;
                    tmr_load  = 1'b1;
                    tmr_value = TimerW'(ClkSettleCycles);
                end else if (tmr_expired) begin
                    // Abort power-off: drop isolation, leave clock and reset alone.
                    state_d  = DONE;
                    iso_en_d = iso_en_clusters_o & ~sel_mask;
                    err_d    = 1'b1;
                end
            end

            CLK_WAIT: begin
                if (tmr_expired) begin
                    if (req_q.on) begin
                        state_d   = RST_WAIT;
                        rst_n_d   = rst_clusters_no | sel_mask;
                        tmr_load  = 1'b1;
                        tmr_value = TimerW'(RstHoldCycles);
                    end else begin
                        state_d      = DONE;
                        rst_n_d      = rst_clusters_no & ~sel_mask;
                        cluster_on_d = cluster_on_o & ~sel_mask;
                    end
                end
            end

            RST_WAIT: begin
                if (tmr_expired) begin
                    state_d   = ACK_WAIT;
                    iso_en_d  = iso_en_clusters_o & ~sel_mask;
                    tmr_load  = 1'b1;
                    tmr_value = TimerW'(IsoTimeoutCycles);
                end
            end

            ACK_WAIT: begin
                if (!ack_sel) begin
                    state_d      = DONE;
                    cluster_on_d = cluster_on_o | sel_mask;
                end else if (tmr_expired) begin
                    // Abort power-on: keep the cluster isolated, clock/reset stay released.
                    state_d  = DONE;
                    iso_en_d = iso_en_clusters_o | sel_mask;
                    err_d    = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

endmodule : chimera_pmu_sequencer

// File: tb/tb_chimera_pmu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chimera_pmu_sequencer
// Self-checking bench: each request pushes its expected completion into a
// scoreboard queue; the completion pulse pops and compares it. Per-cycle
// snapshots are checked inline for the pin-edge timing of each scenario.
// The cluster ack model follows iso_en by two cycles, or can be held at 0.
// -----------------------------------------------------------------------------
module tb_chimera_pmu_sequencer;

    localparam int NC = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_idx = '0;
    logic          req_on = 1'b0;
    logic          done, err, busy;
    logic [NC-1:0] cluster_on, rst_n, clk_en, iso_en, iso_ack;

    logic [NC-1:0] ack_d1 = '0;
    logic [NC-1:0] ack_q  = '0;
    bit            ack_stuck = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string         name;
        int            lat;
        bit            err;
        logic [NC-1:0] on;
        logic [NC-1:0] rst_n;
        logic [NC-1:0] clk_en;
        logic [NC-1:0] iso;
    } exp_t;

    exp_t sb[$];

    // Bench-side model of the committed pin state after each request.
    logic [NC-1:0] m_on, m_rst, m_clk, m_iso;

    // Per-cycle snapshots, index n = cycle Tn relative to the handshake.
    logic [NC-1:0] h_iso [0:127];
    logic [NC-1:0] h_clk [0:127];
    logic [NC-1:0] h_rst [0:127];
    logic [NC-1:0] h_on  [0:127];
    logic          h_rdy [0:127];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ack_d1 <= iso_en;
        ack_q  <= ack_d1;
    end
    assign iso_ack = ack_stuck ? '0 : ack_q;

    chimera_pmu_sequencer #(
        .NumClusters      (NC),
        .BootOn           (5'b11111),
        .ClkSettleCycles  (4),
        .RstHoldCycles    (8),
        .IsoTimeoutCycles (64),
        .IdxW             (3)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_idx_i          (req_idx),
        .req_on_i           (req_on),
        .done_o             (done),
        .err_o              (err),
        .busy_o             (busy),
        .cluster_on_o       (cluster_on),
        .rst_clusters_no    (rst_n),
        .clk_en_clusters_o  (clk_en),
        .iso_en_clusters_o  (iso_en),
        .iso_ack_clusters_i (iso_ack)
    );

    task automatic snap(input int n);
        h_iso[n] = iso_en;
        h_clk[n] = clk_en;
        h_rst[n] = rst_n;
        h_on[n]  = cluster_on;
        h_rdy[n] = req_ready;
    endtask

    task automatic push_exp(input string name, input int lat, input bit e);
        exp_t x;
        x.name = name; x.lat = lat; x.err = e;
        x.on = m_on; x.rst_n = m_rst; x.clk_en = m_clk; x.iso = m_iso;
        sb.push_back(x);
    endtask

    // Drive one request, snapshot each cycle, pop and check on done_o.
    task automatic run_req(input int idx, input bit on);
        exp_t x;
        int   lat;
        bit   seen;
        @(negedge clk);
        snap(0);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready before request: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_idx   = 3'(idx);
        req_on    = on;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n < 120 && !seen; n++) begin
            @(negedge clk);
            snap(n);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        x = sb.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s timeout: no done_o within 120 cycles, want latency %0d", x.name, x.lat);
        end else begin
            if (lat !== x.lat) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want %0d", x.name, lat, x.lat);
            end
            vectors++;
            if (err !== x.err) begin
                miscompares++;
                $display("FAIL %s err_o: got %b want %b", x.name, err, x.err);
            end
            vectors++;
            if ({cluster_on, rst_n, clk_en, iso_en} !== {x.on, x.rst_n, x.clk_en, x.iso}) begin
                miscompares++;
                $display("FAIL %s pins on/rst_n/clk_en/iso: got %b/%b/%b/%b want %b/%b/%b/%b",
                         x.name, cluster_on, rst_n, clk_en, iso_en, x.on, x.rst_n, x.clk_en, x.iso);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        m_on = 5'b11111; m_rst = 5'b11111; m_clk = 5'b11111; m_iso = 5'b00000;
        vectors++;
        if ({cluster_on, rst_n, clk_en, iso_en} !== {m_on, m_rst, m_clk, m_iso}) begin
            miscompares++;
            $display("FAIL reset pins on/rst_n/clk_en/iso: got %b/%b/%b/%b want 11111/11111/11111/00000",
                     cluster_on, rst_n, clk_en, iso_en);
        end
        vectors++;
        if ({req_ready, done, err, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset ready/done/err/busy: got %b%b%b%b want 1000", req_ready, done, err, busy);
        end
    endtask

    task automatic test_power_off();
        bit others_ok;
        m_on = 5'b11011; m_rst = 5'b11011; m_clk = 5'b11011; m_iso = 5'b00100;
        push_exp("off_c2", 8, 1'b0);
        run_req(2, 1'b0);
        vectors++;
        if ({h_iso[0][2], h_iso[1][2]} !== 2'b01) begin
            miscompares++;
            $display("FAIL off_c2 iso edge T0/T1: got %b%b want 01", h_iso[0][2], h_iso[1][2]);
        end
        vectors++;
        if ({h_clk[3][2], h_clk[4][2]} !== 2'b10) begin
            miscompares++;
            $display("FAIL off_c2 clk_en edge T3/T4: got %b%b want 10", h_clk[3][2], h_clk[4][2]);
        end
        vectors++;
        if ({h_rst[7][2], h_rst[8][2]} !== 2'b10) begin
            miscompares++;
            $display("FAIL off_c2 rst_n edge T7/T8: got %b%b want 10", h_rst[7][2], h_rst[8][2]);
        end
        others_ok = 1'b1;
        for (int n = 0; n <= 8; n++) begin
            if ((h_iso[n] & 5'b11011) !== 5'b00000 || (h_clk[n] & 5'b11011) !== 5'b11011 ||
                (h_rst[n] & 5'b11011) !== 5'b11011 || (h_on[n] & 5'b11011) !== 5'b11011)
                others_ok = 1'b0;
        end
        vectors++;
        if (!others_ok) begin
            miscompares++;
            $display("FAIL off_c2 other clusters: got changed bits want unchanged");
        end
    endtask

    task automatic test_power_on();
        m_on = 5'b11111; m_rst = 5'b11111; m_clk = 5'b11111; m_iso = 5'b00000;
        push_exp("on_c2", 16, 1'b0);
        run_req(2, 1'b1);
        vectors++;
        if ({h_clk[0][2], h_clk[1][2]} !== 2'b01) begin
            miscompares++;
            $display("FAIL on_c2 clk_en edge T0/T1: got %b%b want 01", h_clk[0][2], h_clk[1][2]);
        end
        vectors++;
        if ({h_rst[4][2], h_rst[5][2]} !== 2'b01) begin
            miscompares++;
            $display("FAIL on_c2 rst_n edge T4/T5: got %b%b want 01", h_rst[4][2], h_rst[5][2]);
        end
        vectors++;
        if ({h_iso[12][2], h_iso[13][2]} !== 2'b10) begin
            miscompares++;
            $display("FAIL on_c2 iso edge T12/T13: got %b%b want 10", h_iso[12][2], h_iso[13][2]);
        end
    endtask

    task automatic test_timeout();
        ack_stuck = 1'b1;
        // Isolation is dropped again; clock, reset and power state untouched.
        push_exp("off_c0_timeout", 66, 1'b1);
        run_req(0, 1'b0);
        ack_stuck = 1'b0;
        vectors++;
        if (h_iso[65][0] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout iso held in ISO_WAIT T65: got %b want 1", h_iso[65][0]);
        end
    endtask

    task automatic test_illegal_idx();
        push_exp("illegal_idx7", 1, 1'b1);
        run_req(7, 1'b1);
    endtask

    task automatic test_back_to_back();
        push_exp("noop_on_c1", 1, 1'b0);
        run_req(1, 1'b1);
        vectors++;
        if (h_rdy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL noop ready during DONE: got %b want 0", h_rdy[1]);
        end
        // Accepted in the cycle right after done_o.
        push_exp("noop_on_c4", 1, 1'b0);
        run_req(4, 1'b1);
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        req_valid = 1'b1; req_idx = 3'd3; req_on = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        // T1..T4: ISO_ASSERT, ISO_WAIT(2), CLK_WAIT from T4; assert reset in T5.
        repeat (5) @(negedge clk);
        vectors++;
        if (clk_en[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid precondition clk_en[3] at T5: got %b want 0", clk_en[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        m_on = 5'b11111; m_rst = 5'b11111; m_clk = 5'b11111; m_iso = 5'b00000;
        vectors++;
        if ({cluster_on, rst_n, clk_en, iso_en, req_ready, done, err, busy} !==
            {m_on, m_rst, m_clk, m_iso, 4'b1000}) begin
            miscompares++;
            $display("FAIL reset_mid outputs: got %b/%b/%b/%b rdy%b done%b err%b busy%b want reset values",
                     cluster_on, rst_n, clk_en, iso_en, req_ready, done, err, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_mid spurious done_o: got %0d pulses want 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_power_off();
        test_power_on();
        test_timeout();
        test_illegal_idx();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard leftover entries: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_chimera_pmu_sequencer
